// File: rtl/motor_fault_pkg.sv
// Shared types for the motor fault monitor: FSM state encoding, fault codes
// and a saturating increment helper for the trip counter.
package motor_fault_pkg;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      PENDING = 2'd1,
      TRIPPED = 2'd2,
      RECOVER = 2'd3
   } state_t;

   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_OC    = 2'b01;
   localparam logic [1:0] FC_STALL = 2'b10;
   localparam logic [1:0] FC_BOTH  = 2'b11;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/motor_fault_monitor_if.sv
// Sample/fault bus between the ADC/encoder front-end (master) and the motor
// fault monitor (slave).
interface motor_fault_monitor_if #(
   parameter int DATA_W = 16
);

   logic              sample_valid;
   logic [DATA_W-1:0] current_in;
   logic [DATA_W-1:0] speed_in;
   logic              fault_clr;
   logic              fault_detected;
   logic [1:0]        fault_code;
   logic [7:0]        fault_count;
   logic [1:0]        state;

   modport master (
      output sample_valid, current_in, speed_in, fault_clr,
      input  fault_detected, fault_code, fault_count, state
   );

   modport slave (
      input  sample_valid, current_in, speed_in, fault_clr,
      output fault_detected, fault_code, fault_count, state
   );

endinterface

// File: rtl/fault_debounce.sv
// Saturating consecutive-sample counter. reached/active look at the value the
// counter takes on this edge so the owner can act on the qualifying sample itself.
module fault_debounce #(
   parameter int MAX = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic valid,
   input  logic cond,
   input  logic freeze,
   input  logic clear,
   output logic reached,
   output logic active
);

   localparam int CNT_W = $clog2(MAX + 1);
   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   // next count: hold when frozen or no sample, restart on a non-qualifying sample
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (freeze) begin
         cnt_nxt_s = cnt_r;
      end else if (valid) begin
         if (!cond) begin
            cnt_nxt_s = {CNT_W{1'b0}};
         end else if (cnt_r == MAX_V) begin
            cnt_nxt_s = cnt_r;
         end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // counter register; clear wins over the computed next value
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end

   assign reached = (cnt_nxt_s == MAX_V);
   assign active  = (cnt_nxt_s != {CNT_W{1'b0}});

endmodule

// File: rtl/motor_fault_monitor.sv
// Debounced overcurrent/stall fault latch with hysteresis-qualified recovery.
// Optional FAULT_AUTO_CLEAR_EN: a clean sample also releases TRIPPED without fault_clr.
module motor_fault_monitor
   import motor_fault_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int CURR_THRESH    = 3000,
   parameter int CURR_HYST      = 200,
   parameter int STALL_CURR     = 1500,
   parameter int SPEED_MIN      = 100,
   parameter int DEBOUNCE       = 5,
   parameter int RECOVERY_COUNT = 16
) (
   input logic                  clk,
   input logic                  rst,
   motor_fault_monitor_if.slave bus
);

   localparam int REC_W = $clog2(RECOVERY_COUNT + 1);
   localparam logic [REC_W-1:0]  REC_TARGET = REC_W'(RECOVERY_COUNT);
   localparam logic [DATA_W-1:0] OC_LVL     = DATA_W'(CURR_THRESH);
   localparam logic [DATA_W-1:0] CLEAN_LVL  = DATA_W'(CURR_THRESH - CURR_HYST);
   localparam logic [DATA_W-1:0] STALL_LVL  = DATA_W'(STALL_CURR);
   localparam logic [DATA_W-1:0] SPEED_LVL  = DATA_W'(SPEED_MIN);

   if ((CURR_HYST > CURR_THRESH) || (DEBOUNCE < 1) || (RECOVERY_COUNT < 1)) begin : g_param_err
      $error("motor_fault_monitor: illegal parameter combination");
   end

   state_t           state_r;
   state_t           state_nxt;
   logic [REC_W-1:0] rec_r;
   logic [REC_W-1:0] rec_nxt;
   logic [REC_W-1:0] rec_first_s;
   logic [REC_W-1:0] rec_inc_s;
   logic [1:0]       code_r;
   logic [1:0]       code_nxt;
   logic [7:0]       count_r;
   logic             detected_r;

   logic oc_s;
   logic stall_s;
   logic clean_s;
   logic clean_sample_s;
   logic leave_trip_s;
   logic freeze_s;
   logic clear_s;
   logic trip_s;
   logic oc_reached_s;
   logic oc_active_s;
   logic stall_reached_s;
   logic stall_active_s;

   assign oc_s           = (bus.current_in > OC_LVL);
   assign stall_s        = (bus.current_in > STALL_LVL) && (bus.speed_in < SPEED_LVL);
   assign clean_s        = (bus.current_in < CLEAN_LVL) && !stall_s;
   assign clean_sample_s = bus.sample_valid && clean_s;
   assign freeze_s       = (state_r == TRIPPED) || (state_r == RECOVER);
   assign rec_first_s    = clean_sample_s ? REC_W'(1) : {REC_W{1'b0}};
   assign rec_inc_s      = rec_r + REC_W'(1);

`ifdef FAULT_AUTO_CLEAR_EN
   assign leave_trip_s = bus.fault_clr || clean_sample_s;
`else
   assign leave_trip_s = bus.fault_clr;
`endif

   fault_debounce #(.MAX(DEBOUNCE)) u_oc_debounce (
      .clk     (clk),
      .rst     (rst),
      .valid   (bus.sample_valid),
      .cond    (oc_s),
      .freeze  (freeze_s),
      .clear   (clear_s),
      .reached (oc_reached_s),
      .active  (oc_active_s)
   );

   fault_debounce #(.MAX(DEBOUNCE)) u_stall_debounce (
      .clk     (clk),
      .rst     (rst),
      .valid   (bus.sample_valid),
      .cond    (stall_s),
      .freeze  (freeze_s),
      .clear   (clear_s),
      .reached (stall_reached_s),
      .active  (stall_active_s)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= NORMAL;
      end else begin
         state_r <= state_nxt;
      end
   end

   // next state, recovery count and fault code; trips act on the qualifying sample
   always_comb begin
      state_nxt = state_r;
      rec_nxt   = rec_r;
      code_nxt  = code_r;
      trip_s    = 1'b0;
      clear_s   = 1'b0;
      case (state_r)
         NORMAL, PENDING: begin
            if (oc_reached_s || stall_reached_s) begin
               state_nxt = TRIPPED;
               trip_s    = 1'b1;
               case ({stall_reached_s, oc_reached_s})
                  2'b11:   code_nxt = FC_BOTH;
                  2'b10:   code_nxt = FC_STALL;
                  2'b01:   code_nxt = FC_OC;
                  default: code_nxt = FC_NONE;
               endcase
            end else if (oc_active_s || stall_active_s) begin
               state_nxt = PENDING;
            end else begin
               state_nxt = NORMAL;
            end
         end
         TRIPPED: begin
            // a clean sample arriving with the release already counts toward recovery
            if (!leave_trip_s) begin
               state_nxt = TRIPPED;
            end else if (rec_first_s == REC_TARGET) begin
               state_nxt = NORMAL;
               rec_nxt   = {REC_W{1'b0}};
               code_nxt  = FC_NONE;
               clear_s   = 1'b1;
            end else begin
               state_nxt = RECOVER;
               rec_nxt   = rec_first_s;
            end
         end
         RECOVER: begin
            if (clean_sample_s) begin
               if (rec_inc_s == REC_TARGET) begin
                  state_nxt = NORMAL;
                  rec_nxt   = {REC_W{1'b0}};
                  code_nxt  = FC_NONE;
                  clear_s   = 1'b1;
               end else begin
                  rec_nxt = rec_inc_s;
               end
            end else if (bus.sample_valid) begin
               rec_nxt = {REC_W{1'b0}};
            end else begin
               rec_nxt = rec_r;
            end
         end
         default: begin
            state_nxt = NORMAL;
            rec_nxt   = {REC_W{1'b0}};
            code_nxt  = FC_NONE;
            clear_s   = 1'b1;
         end
      endcase
   end

   // registered outputs and recovery counter
   always_ff @(posedge clk) begin
      if (rst) begin
         detected_r <= 1'b0;
         code_r     <= FC_NONE;
         count_r    <= 8'd0;
         rec_r      <= {REC_W{1'b0}};
      end else begin
         detected_r <= (state_nxt == TRIPPED) || (state_nxt == RECOVER);
         code_r     <= code_nxt;
         count_r    <= trip_s ? sat_inc8(count_r) : count_r;
         rec_r      <= rec_nxt;
      end
   end

   assign bus.fault_detected = detected_r;
   assign bus.fault_code     = code_r;
   assign bus.fault_count    = count_r;
   assign bus.state          = state_r;

endmodule

// File: tb/tb_motor_fault_monitor.sv
// Scoreboard bench for motor_fault_monitor: a spec-level model pushes expected
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_motor_fault_monitor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   motor_fault_monitor_if #(.DATA_W(16)) bus_if ();

   motor_fault_monitor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      int det;
      int code;
      int count;
      int st;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   int m_state = 0;
   int m_oc    = 0;
   int m_st    = 0;
   int m_rec   = 0;
   int m_code  = 0;
   int m_count = 0;

   task automatic check(input string tag, input int obs, input int expv);
      checks++;
      if (obs != expv) begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit v, input int c, input int s, input bit clr);
      bit oc, st, cl, go;
      if (r) begin
         m_state = 0; m_oc = 0; m_st = 0; m_rec = 0; m_code = 0; m_count = 0;
      end else begin
         oc = (c > 3000);
         st = (c > 1500) && (s < 100);
         cl = (c < 2800) && !st;
         if (m_state == 0 || m_state == 1) begin
            if (v) begin
               m_oc = oc ? ((m_oc < 5) ? m_oc + 1 : 5) : 0;
               m_st = st ? ((m_st < 5) ? m_st + 1 : 5) : 0;
            end
            if (m_oc == 5 || m_st == 5) begin
               m_state = 2;
               m_code  = ((m_oc == 5) ? 1 : 0) + ((m_st == 5) ? 2 : 0);
               if (m_count < 255) m_count++;
            end else begin
               m_state = (m_oc != 0 || m_st != 0) ? 1 : 0;
            end
         end else if (m_state == 2) begin
            go = clr;
`ifdef FAULT_AUTO_CLEAR_EN
            go = go || (v && cl);
`endif
            if (go) begin
               m_rec   = (v && cl) ? 1 : 0;
               m_state = 3;
            end
         end else begin
            if (v) m_rec = cl ? m_rec + 1 : 0;
            if (m_rec == 16) begin
               m_state = 0; m_rec = 0; m_oc = 0; m_st = 0; m_code = 0;
            end
         end
      end
   endtask

   task automatic step(input bit r, input bit v, input int c, input int s, input bit clr);
      exp_t e;
      rst                 = r;
      bus_if.sample_valid = v;
      bus_if.current_in   = 16'(c);
      bus_if.speed_in     = 16'(s);
      bus_if.fault_clr    = clr;
      model_step(r, v, c, s, clr);
      e.det   = (m_state == 2 || m_state == 3) ? 1 : 0;
      e.code  = m_code;
      e.count = m_count;
      e.st    = m_state;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("queue_empty", 0, 1);
      end else begin
         e = exp_q.pop_front();
         check("fault_detected", int'(bus_if.fault_detected), e.det);
         check("fault_code", int'(bus_if.fault_code), e.code);
         check("fault_count", int'(bus_if.fault_count), e.count);
         check("state", int'(bus_if.state), e.st);
      end
   endtask

   task automatic sample(input int c, input int s);
      step(1'b0, 1'b1, c, s, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic clear_req();
      step(1'b0, 1'b0, 0, 0, 1'b1);
   endtask

   task automatic trip_oc();
      for (int i = 0; i < 5; i++) sample(3500, 1000);
   endtask

   task automatic recover_all();
      clear_req();
      for (int i = 0; i < 16; i++) sample(2500, 1000);
   endtask

   initial begin
      bus_if.sample_valid = 1'b0;
      bus_if.current_in   = 16'd0;
      bus_if.speed_in     = 16'd0;
      bus_if.fault_clr    = 1'b0;
      step(1'b1, 1'b0, 0, 0, 1'b0);
      step(1'b1, 1'b0, 0, 0, 1'b0);
      check("reset_state", int'(bus_if.state), 0);
      check("reset_count", int'(bus_if.fault_count), 0);

      // 1: overcurrent trip, one cycle after the fifth sample
      for (int i = 0; i < 4; i++) sample(3500, 1000);
      check("t1_no_trip_at_4", int'(bus_if.fault_detected), 0);
      sample(3500, 1000);
      check("t1_det", int'(bus_if.fault_detected), 1);
      check("t1_code", int'(bus_if.fault_code), 1);
      check("t1_state", int'(bus_if.state), 2);
      check("t1_count", int'(bus_if.fault_count), 1);
      recover_all();
      check("t1_cleared", int'(bus_if.fault_detected), 0);

      // 2: gaps do not break the run; a low sample aborts it
      clear_req();
      for (int i = 0; i < 4; i++) begin
         sample(3500, 1000);
         idle();
      end
      check("t2_pending", int'(bus_if.state), 1);
      sample(2000, 1000);
      check("t2_back_normal", int'(bus_if.state), 0);
      for (int i = 0; i < 6; i++) sample(3000, 1000);
      check("t2_thresh_exact", int'(bus_if.state), 0);
      for (int i = 0; i < 6; i++) sample(2000, 100);
      check("t2_speed_exact", int'(bus_if.state), 0);

      // 3: stall only, then both on the same sample
      for (int i = 0; i < 5; i++) sample(2000, 50);
      check("t3_code_stall", int'(bus_if.fault_code), 2);
      recover_all();
      for (int i = 0; i < 5; i++) sample(3500, 50);
      check("t3_code_both", int'(bus_if.fault_code), 3);
      // clear together with a non-clean sample enters RECOVER from zero
      step(1'b0, 1'b1, 3500, 50, 1'b1);
      check("t3_recover", int'(bus_if.state), 3);
      for (int i = 0; i < 15; i++) sample(2500, 1000);
      sample(2800, 1000);
      for (int i = 0; i < 16; i++) sample(2500, 1000);
      check("t3_cleared", int'(bus_if.state), 0);

      // 4: hysteresis recovery restart
      trip_oc();
      clear_req();
      for (int i = 0; i < 15; i++) sample(2500, 1000);
      sample(2900, 1000);
      for (int i = 0; i < 15; i++) sample(2500, 1000);
      check("t4_held", int'(bus_if.fault_detected), 1);
      sample(2500, 1000);
      check("t4_det_clr", int'(bus_if.fault_detected), 0);
      check("t4_code_clr", int'(bus_if.fault_code), 0);

      // 5: reset in RECOVER and in PENDING, then trip counter saturation
      trip_oc();
      clear_req();
      for (int i = 0; i < 3; i++) sample(2500, 1000);
      step(1'b1, 1'b1, 3500, 1000, 1'b0);
      check("t5_rst_recover_det", int'(bus_if.fault_detected), 0);
      check("t5_rst_recover_st", int'(bus_if.state), 0);
      sample(3500, 1000);
      sample(3500, 1000);
      step(1'b1, 1'b1, 3500, 1000, 1'b0);
      check("t5_rst_pending_st", int'(bus_if.state), 0);
      for (int i = 0; i < 4; i++) sample(3500, 1000);
      check("t5_counter_cleared", int'(bus_if.fault_detected), 0);
      sample(1000, 1000);
      for (int t = 0; t < 256; t++) begin
         trip_oc();
         if (t == 254) check("t5_count_255", int'(bus_if.fault_count), 255);
         recover_all();
      end
      check("t5_count_sat", int'(bus_if.fault_count), 255);

      // 6: clean samples without fault_clr
      trip_oc();
      for (int i = 0; i < 16; i++) sample(2500, 1000);
`ifdef FAULT_AUTO_CLEAR_EN
      check("t6_auto_clear", int'(bus_if.fault_detected), 0);
`else
      check("t6_latched", int'(bus_if.fault_detected), 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
